// File: rtl/wb_write_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : wb_write_arbiter_if
//  Description : Bus bundle between the writeback sources / decode and the
//                register-file write arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface wb_write_arbiter_if #(
   parameter int DEPTH = 4
);
   // pipeline writeback
   logic                     pipe_we;
   logic [4:0]               pipe_wa;
   logic [31:0]              pipe_wd;
   // long-latency results
   logic                     lr_valid;
   logic [4:0]               lr_wa;
   logic [31:0]              lr_wd;
   logic                     lr_ready;
   // decode hazard query
   logic [4:0]               ra1;
   logic [4:0]               ra2;
   logic                     pend1;
   logic                     pend2;
   logic                     stall_req;
   // register file write port
   logic                     we3;
   logic [4:0]               wa3;
   logic [31:0]              wd3;
   logic [$clog2(DEPTH):0]   count;

   modport master (
      output pipe_we, pipe_wa, pipe_wd,
      output lr_valid, lr_wa, lr_wd,
      output ra1, ra2,
      input  lr_ready, pend1, pend2, stall_req,
      input  we3, wa3, wd3, count
   );

   modport slave (
      input  pipe_we, pipe_wa, pipe_wd,
      input  lr_valid, lr_wa, lr_wd,
      input  ra1, ra2,
      output lr_ready, pend1, pend2, stall_req,
      output we3, wa3, wd3, count
   );
endinterface
`default_nettype wire

// File: rtl/wb_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : wb_write_arbiter
//  Description : Merges in-order pipeline writeback with queued long-latency
//                results onto the single register-file write port. Queued
//                results drain into free slots; pending writes are reported
//                to decode and a starving FIFO head raises stall_req.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_write_arbiter #(
   parameter int DEPTH      = 4,
   parameter int STARVE_MAX = 8
) (
   input  wire logic          clk,
   input  wire logic          reset,
   wb_write_arbiter_if.slave  bus
);

   localparam int c_AW = $clog2(DEPTH);
   localparam int c_CW = c_AW + 1;
   localparam int c_GW = $clog2(STARVE_MAX + 1);

   // FIFO storage; a cleared valid bit marks a dead (killed) entry
   logic [DEPTH-1:0] r_vld;
   logic [4:0]       r_wa [DEPTH];
   logic [31:0]      r_wd [DEPTH];
   logic [c_AW-1:0]  r_rd_ptr;
   logic [c_AW-1:0]  r_wr_ptr;
   logic [c_CW-1:0]  r_count;

   logic [c_GW-1:0]  r_age;
   logic             r_stall;

   logic             r_we3;
   logic [4:0]       r_wa3;
   logic [31:0]      r_wd3;

   logic             w_full;
   logic             w_empty;
   logic             w_head_live;
   logic             w_head_kill;
   logic             w_pipe_acc;
   logic             w_pop;
   logic             w_push;
   logic [c_CW-1:0]  w_count_nxt;
   logic [c_GW-1:0]  w_age_nxt;
   logic             w_hit1;
   logic             w_hit2;

   assign w_full      = (r_count == c_CW'(DEPTH));
   assign w_empty     = (r_count == '0);
   assign w_head_live = !w_empty && r_vld[r_rd_ptr];
   assign w_pipe_acc  = bus.pipe_we && (bus.pipe_wa != 5'd0);
   assign w_head_kill = w_pipe_acc && (r_wa[r_rd_ptr] == bus.pipe_wa);
   // A dead head always leaves; a live head only takes a slot the pipe left free
   assign w_pop       = !w_empty && (!r_vld[r_rd_ptr] || !w_pipe_acc);
   // Writes to r0 are accepted (handshake completes) but never stored
   assign w_push      = bus.lr_valid && !w_full && (bus.lr_wa != 5'd0);

   // Occupancy: push and pop on the same edge cancel out
   always_comb begin
      w_count_nxt = r_count;
      if (w_push && !w_pop) begin
         w_count_nxt = r_count + c_CW'(1);
      end else if (!w_push && w_pop) begin
         w_count_nxt = r_count - c_CW'(1);
      end
   end

   // Head waiting time: counts only while a live head is passed over
   always_comb begin
      w_age_nxt = r_age;
      if (w_pop || !w_head_live || w_head_kill) begin
         w_age_nxt = '0;
      end else if (r_age < c_GW'(STARVE_MAX)) begin
         w_age_nxt = r_age + c_GW'(1);
      end
   end

   // Associative match of decode read addresses against live entries
   always_comb begin
      w_hit1 = 1'b0;
      w_hit2 = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (r_vld[i] && (r_wa[i] == bus.ra1)) w_hit1 = 1'b1;
         if (r_vld[i] && (r_wa[i] == bus.ra2)) w_hit2 = 1'b1;
      end
   end

   // FIFO update: kill matching entries, then pop, then push (push wins)
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_vld    <= '0;
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_wa[i] <= '0;
            r_wd[i] <= '0;
         end
      end else begin
         if (w_pipe_acc) begin
            for (int i = 0; i < DEPTH; i++) begin
               if (r_wa[i] == bus.pipe_wa) r_vld[i] <= 1'b0;
            end
         end
         if (w_pop) begin
            r_vld[r_rd_ptr] <= 1'b0;
            r_rd_ptr        <= r_rd_ptr + c_AW'(1);
         end
         if (w_push) begin
            r_vld[r_wr_ptr] <= 1'b1;
            r_wa[r_wr_ptr]  <= bus.lr_wa;
            r_wd[r_wr_ptr]  <= bus.lr_wd;
            r_wr_ptr        <= r_wr_ptr + c_AW'(1);
         end
         r_count <= w_count_nxt;
      end
   end

   // Registered write port: pipeline first, then a live FIFO head, else idle
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_we3 <= 1'b0;
         r_wa3 <= '0;
         r_wd3 <= '0;
      end else if (w_pipe_acc) begin
         r_we3 <= 1'b1;
         r_wa3 <= bus.pipe_wa;
         r_wd3 <= bus.pipe_wd;
      end else if (w_head_live) begin
         r_we3 <= 1'b1;
         r_wa3 <= r_wa[r_rd_ptr];
         r_wd3 <= r_wd[r_rd_ptr];
      end else begin
         r_we3 <= 1'b0;
         r_wa3 <= '0;
         r_wd3 <= '0;
      end
   end

   // Starvation tracking; stall_req is the registered saturation flag
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_age   <= '0;
         r_stall <= 1'b0;
      end else begin
         r_age   <= w_age_nxt;
         r_stall <= (w_age_nxt >= c_GW'(STARVE_MAX));
      end
   end

   assign bus.lr_ready  = !w_full;
   assign bus.pend1     = (bus.ra1 != 5'd0) && w_hit1;
   assign bus.pend2     = (bus.ra2 != 5'd0) && w_hit2;
   assign bus.stall_req = r_stall;
   assign bus.we3       = r_we3;
   assign bus.wa3       = r_wa3;
   assign bus.wd3       = r_wd3;
   assign bus.count     = r_count;

endmodule
`default_nettype wire

// File: tb/tb_wb_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_write_arbiter
//  Description : Self-checking bench for wb_write_arbiter: directed scenarios
//                plus randomized traffic against a queue-based model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_write_arbiter;

   localparam int DEPTH      = 4;
   localparam int STARVE_MAX = 8;

   typedef struct {
      bit          live;
      logic [4:0]  wa;
      logic [31:0] wd;
   } ent_t;

   logic clk;
   logic rst;
   int   tests;
   int   fails;

   // reference model state
   ent_t        q[$];
   int          m_wait;
   logic        exp_we;
   logic [4:0]  exp_wa;
   logic [31:0] exp_wd;
   logic        exp_stall;

   wb_write_arbiter_if #(.DEPTH(DEPTH)) bus ();

   wb_write_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
      .clk   (clk),
      .reset (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish (actual running, required done)");
      $fatal(1, "timeout");
   end

   function automatic void model_reset();
      q.delete();
      m_wait    = 0;
      exp_we    = 1'b0;
      exp_wa    = '0;
      exp_wd    = '0;
      exp_stall = 1'b0;
   endfunction

   // One rising edge of the arbiter described as queue operations
   function automatic void model_edge();
      bit   pacc;
      bit   full_before;
      bit   popped;
      ent_t e;
      pacc        = bus.pipe_we && (bus.pipe_wa != 0);
      full_before = (q.size() >= DEPTH);
      popped      = 0;
      exp_we = 1'b0; exp_wa = '0; exp_wd = '0;
      if (pacc) begin
         exp_we = 1'b1; exp_wa = bus.pipe_wa; exp_wd = bus.pipe_wd;
      end
      if (q.size() > 0) begin
         if (!q[0].live) begin
            void'(q.pop_front());
            popped = 1;
         end else if (!pacc) begin
            e = q.pop_front();
            exp_we = 1'b1; exp_wa = e.wa; exp_wd = e.wd;
            popped = 1;
         end
      end
      if (pacc) begin
         foreach (q[i]) if (q[i].wa == bus.pipe_wa) q[i].live = 0;
      end
      if (popped || q.size() == 0 || !q[0].live) m_wait = 0;
      else if (m_wait < STARVE_MAX) m_wait++;
      exp_stall = (m_wait >= STARVE_MAX);
      if (bus.lr_valid && !full_before && bus.lr_wa != 0) begin
         e.live = 1; e.wa = bus.lr_wa; e.wd = bus.lr_wd;
         q.push_back(e);
      end
   endfunction

   function automatic bit model_pend(input logic [4:0] ra);
      if (ra == 0) return 1'b0;
      foreach (q[i]) if (q[i].live && q[i].wa == ra) return 1'b1;
      return 1'b0;
   endfunction

   task automatic drive(input bit pwe, input logic [4:0] pwa, input logic [31:0] pwd,
                        input bit lv, input logic [4:0] lwa, input logic [31:0] lwd);
      bus.pipe_we  = pwe;
      bus.pipe_wa  = pwa;
      bus.pipe_wd  = pwd;
      bus.lr_valid = lv;
      bus.lr_wa    = lwa;
      bus.lr_wd    = lwd;
   endtask

   // Advance one clock; the model tracks every edge; sample 1 ns later
   task automatic cyc();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic test_reset();
      drive(0, 0, 0, 0, 0, 0);
      bus.ra1 = 0; bus.ra2 = 0;
      rst = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      tests++; if (bus.we3 !== 1'b0) begin fails++; $display("FAIL reset_we3 actual=%0b required=0", bus.we3); end
      tests++; if (bus.wa3 !== 5'd0) begin fails++; $display("FAIL reset_wa3 actual=%0d required=0", bus.wa3); end
      tests++; if (bus.wd3 !== 32'd0) begin fails++; $display("FAIL reset_wd3 actual=%h required=0", bus.wd3); end
      tests++; if (bus.count !== 3'd0) begin fails++; $display("FAIL reset_count actual=%0d required=0", bus.count); end
      tests++; if (bus.lr_ready !== 1'b1) begin fails++; $display("FAIL reset_lr_ready actual=%0b required=1", bus.lr_ready); end
      tests++; if (bus.stall_req !== 1'b0) begin fails++; $display("FAIL reset_stall actual=%0b required=0", bus.stall_req); end
      tests++; if (bus.pend1 !== 1'b0 || bus.pend2 !== 1'b0) begin fails++; $display("FAIL reset_pend actual=%0b%0b required=00", bus.pend1, bus.pend2); end
      rst = 1'b0;
   endtask

   task automatic test_reset_mid_queue();
      for (int i = 0; i < 3; i++) begin
         drive(1, 5'd1, 32'h100 + i, 1, 5'(10 + i), 32'h500 + i);
         cyc();
      end
      drive(0, 0, 0, 0, 0, 0);
      tests++; if (bus.count !== 3'd3) begin fails++; $display("FAIL midq_count_before actual=%0d required=3", bus.count); end
      rst = 1'b1;
      model_reset();
      #1;
      tests++; if (bus.count !== 3'd0) begin fails++; $display("FAIL midq_count_reset actual=%0d required=0", bus.count); end
      tests++; if (bus.lr_ready !== 1'b1) begin fails++; $display("FAIL midq_lr_ready actual=%0b required=1", bus.lr_ready); end
      #1;
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         cyc();
         tests++; if (bus.we3 !== 1'b0) begin fails++; $display("FAIL midq_no_write cyc=%0d actual=%0b required=0", i, bus.we3); end
      end
      tests++; if (bus.count !== 3'd0) begin fails++; $display("FAIL midq_count_after actual=%0d required=0", bus.count); end
   endtask

   task automatic test_same_edge();
      drive(1, 5'd5, 32'hAAAA0001, 1, 5'd6, 32'h1234);
      cyc();
      drive(0, 0, 0, 0, 0, 0);
      tests++; if (bus.we3 !== 1'b1 || bus.wa3 !== 5'd5 || bus.wd3 !== 32'hAAAA0001) begin
         fails++; $display("FAIL same_edge_c1 actual=%0b/%0d/%h required=1/5/aaaa0001", bus.we3, bus.wa3, bus.wd3); end
      cyc();
      tests++; if (bus.we3 !== 1'b1 || bus.wa3 !== 5'd6 || bus.wd3 !== 32'h1234) begin
         fails++; $display("FAIL same_edge_c2 actual=%0b/%0d/%h required=1/6/00001234", bus.we3, bus.wa3, bus.wd3); end
      tests++; if (bus.count !== 3'd0) begin fails++; $display("FAIL same_edge_count actual=%0d required=0", bus.count); end
   endtask

   task automatic test_full_starve();
      for (int i = 0; i < 4; i++) begin
         drive(1, 5'd1, $urandom, 1, 5'(20 + i), 32'hC0 + i);
         cyc();
      end
      tests++; if (bus.lr_ready !== 1'b0) begin fails++; $display("FAIL full_lr_ready actual=%0b required=0", bus.lr_ready); end
      drive(1, 5'd1, $urandom, 1, 5'd24, 32'hDEAD);
      cyc();
      tests++; if (bus.count !== 3'd4) begin fails++; $display("FAIL full_count actual=%0d required=4", bus.count); end
      for (int i = 0; i < 3; i++) begin
         drive(1, 5'd1, $urandom, 0, 0, 0);
         cyc();
         tests++; if (bus.stall_req !== 1'b0) begin fails++; $display("FAIL starve_early cyc=%0d actual=%0b required=0", i, bus.stall_req); end
      end
      for (int i = 0; i < 2; i++) begin
         cyc();
         tests++; if (bus.stall_req !== 1'b1) begin fails++; $display("FAIL starve_set cyc=%0d actual=%0b required=1", i, bus.stall_req); end
      end
      drive(0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         cyc();
         tests++; if (bus.we3 !== 1'b1 || bus.wa3 !== 5'(20 + i) || bus.wd3 !== 32'hC0 + i) begin
            fails++; $display("FAIL drain_order idx=%0d actual=%0b/%0d/%h required=1/%0d/%h", i, bus.we3, bus.wa3, bus.wd3, 20 + i, 32'hC0 + i); end
         tests++; if (bus.stall_req !== 1'b0) begin fails++; $display("FAIL drain_stall idx=%0d actual=%0b required=0", i, bus.stall_req); end
      end
      cyc();
      tests++; if (bus.we3 !== 1'b0 || bus.count !== 3'd0) begin fails++; $display("FAIL drain_done actual=%0b/%0d required=0/0", bus.we3, bus.count); end
   endtask

   task automatic test_kill();
      bus.ra1 = 5'd7;
      drive(1, 5'd1, 32'h11, 1, 5'd7, 32'h77);
      cyc();
      tests++; if (bus.pend1 !== 1'b1) begin fails++; $display("FAIL kill_pend_before actual=%0b required=1", bus.pend1); end
      drive(1, 5'd7, 32'h99, 0, 0, 0);
      cyc();
      tests++; if (bus.we3 !== 1'b1 || bus.wa3 !== 5'd7 || bus.wd3 !== 32'h99) begin
         fails++; $display("FAIL kill_pipe_write actual=%0b/%0d/%h required=1/7/00000099", bus.we3, bus.wa3, bus.wd3); end
      tests++; if (bus.pend1 !== 1'b0) begin fails++; $display("FAIL kill_pend_after actual=%0b required=0", bus.pend1); end
      drive(0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         cyc();
         tests++; if (bus.we3 !== 1'b0) begin fails++; $display("FAIL kill_no_stale cyc=%0d actual=%0b/%0d/%h required=0", i, bus.we3, bus.wa3, bus.wd3); end
      end
      tests++; if (bus.count !== 3'd0) begin fails++; $display("FAIL kill_count actual=%0d required=0", bus.count); end
   endtask

   task automatic test_zero_addr();
      bus.ra1 = 5'd0;
      drive(1, 5'd0, 32'h1111, 1, 5'd0, 32'h2222);
      cyc();
      tests++; if (bus.count !== 3'd0) begin fails++; $display("FAIL zero_count actual=%0d required=0", bus.count); end
      tests++; if (bus.we3 !== 1'b0) begin fails++; $display("FAIL zero_we3 actual=%0b required=0", bus.we3); end
      tests++; if (bus.pend1 !== 1'b0) begin fails++; $display("FAIL zero_pend1 actual=%0b required=0", bus.pend1); end
      tests++; if (bus.lr_ready !== 1'b1) begin fails++; $display("FAIL zero_lr_ready actual=%0b required=1", bus.lr_ready); end
      drive(0, 0, 0, 0, 0, 0);
      cyc();
   endtask

   task automatic test_random();
      for (int n = 0; n < 500; n++) begin
         drive(($urandom_range(0, 99) < 55), 5'($urandom_range(0, 7)), $urandom,
               ($urandom_range(0, 99) < 50), 5'($urandom_range(0, 7)), $urandom);
         bus.ra1 = 5'($urandom_range(0, 7));
         bus.ra2 = 5'($urandom_range(0, 7));
         cyc();
         tests++; if (bus.we3 !== exp_we || bus.wa3 !== exp_wa || bus.wd3 !== exp_wd) begin
            fails++; $display("FAIL rand_write n=%0d actual=%0b/%0d/%h required=%0b/%0d/%h", n, bus.we3, bus.wa3, bus.wd3, exp_we, exp_wa, exp_wd); end
         tests++; if (bus.count !== 3'(q.size())) begin
            fails++; $display("FAIL rand_count n=%0d actual=%0d required=%0d", n, bus.count, q.size()); end
         tests++; if (bus.stall_req !== exp_stall) begin
            fails++; $display("FAIL rand_stall n=%0d actual=%0b required=%0b", n, bus.stall_req, exp_stall); end
         tests++; if (bus.lr_ready !== (q.size() < DEPTH)) begin
            fails++; $display("FAIL rand_lr_ready n=%0d actual=%0b required=%0b", n, bus.lr_ready, (q.size() < DEPTH)); end
         tests++; if (bus.pend1 !== model_pend(bus.ra1) || bus.pend2 !== model_pend(bus.ra2)) begin
            fails++; $display("FAIL rand_pend n=%0d actual=%0b%0b required=%0b%0b", n, bus.pend1, bus.pend2, model_pend(bus.ra1), model_pend(bus.ra2)); end
      end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      rst   = 1'b1;
      drive(0, 0, 0, 0, 0, 0);
      bus.ra1 = 0;
      bus.ra2 = 0;
      test_reset();
      test_reset_mid_queue();
      test_same_edge();
      test_full_starve();
      test_kill();
      test_zero_addr();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
